// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding, word
// framing constants, header decoding and the big-endian byte-lane mapping.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_WRITE,
    ST_CHK,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam int BYTES_PER_WORD     = 4;
  localparam int BYTE_IDX_W         = 2;
  localparam bit HDR_ZERO_MEANS_256 = 1'b1;

  // Big-endian lane mapping: each new byte enters at [7:0] and older bytes
  // move up, so the first byte of a word ends up in [31:24].
  function automatic logic [31:0] pack_byte(input logic [31:0] word,
                                            input logic [7:0]  b);
    return {word[23:0], b};
  endfunction

  // Header byte to word count; a zero header stands for a full 256 words.
  function automatic logic [8:0] hdr_count(input logic [7:0] hdr);
    if (HDR_ZERO_MEANS_256 && (hdr == 8'd0)) return 9'd256;
    return {1'b0, hdr};
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and program-RAM write port of the program loader.
// master: stream source / RAM observer; slave: the loader itself.
interface program_loader_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic [7:0]        in_byte;
  logic              in_ready;
  logic              mem_w;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_w_data;

  modport master (
    output in_valid, in_byte,
    input  in_ready, mem_w, mem_addr, mem_w_data
  );

  modport slave (
    input  in_valid, in_byte,
    output in_ready, mem_w, mem_addr, mem_w_data
  );
endinterface

// File: rtl/program_loader_byte_packer.sv
// Collects four stream bytes into one 32-bit instruction word. word_next is
// the word including the byte being shifted in this cycle; word_ready flags
// that this byte completes the word.
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_next,
  output logic        word_ready
);

  logic [31:0]           shreg;
  logic [BYTE_IDX_W-1:0] idx;

  assign word_next  = pack_byte(shreg, byte_in);
  assign word_ready = shift_en && (idx == BYTE_IDX_W'(BYTES_PER_WORD - 1));

  // Byte index: wraps 0..3, restarted for every new image or on reset.
  always_ff @(posedge clk) begin
    if (reset || clear) idx <= '0;
    else if (shift_en)  idx <= idx + BYTE_IDX_W'(1);
  end

  // Shift register is pure data; stale bytes are fully replaced within a word.
  always_ff @(posedge clk) begin
    if (shift_en) shreg <= word_next;
  end

endmodule

// File: rtl/program_loader.sv
// Program loader: receives a framed byte stream (header N, then 4 bytes per
// word), writes the words to sequential program-RAM addresses and holds the
// CPU in reset until the image is complete.
// Optional macro LOADER_CHECKSUM_EN: a trailer byte follows the image and
// must make the XOR of header, data and trailer zero before DONE.
module program_loader
  import loader_pkg::*;
#(
  parameter int RAM_SIZE = 256,
  parameter int ADDR_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  program_loader_if.slave   bus,
  input  logic              start,
  output logic              cpu_reset,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int         CNT_W     = ADDR_W + 1;
  localparam logic [8:0] RAM_LIMIT = 9'(RAM_SIZE);

  state_t           state;
  logic [CNT_W-1:0] n_words;
  logic [CNT_W-1:0] wl_inc;
  logic [8:0]       hdr_n;
  logic             accept;
  logic             hdr_accept;
  logic             data_accept;
  logic [31:0]      word_next;
  logic             word_ready;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]       csum;
`endif

  assign accept      = bus.in_valid && bus.in_ready;
  assign hdr_accept  = (state == ST_IDLE) && accept;
  assign data_accept = (state == ST_DATA) && accept;
  assign hdr_n       = hdr_count(bus.in_byte);
  assign wl_inc      = words_loaded + CNT_W'(1);

  byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (hdr_accept),
    .shift_en   (data_accept),
    .byte_in    (bus.in_byte),
    .word_next  (word_next),
    .word_ready (word_ready)
  );

  // Latched word count and running checksum; data registers without reset.
  always_ff @(posedge clk) begin
    if (hdr_accept) n_words <= CNT_W'(hdr_n);
`ifdef LOADER_CHECKSUM_EN
    if (hdr_accept)       csum <= bus.in_byte;
    else if (data_accept) csum <= csum ^ bus.in_byte;
`endif
  end

  // Load sequencer with registered handshake, RAM-write and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      bus.in_ready   <= 1'b0;
      bus.mem_w      <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_w_data <= '0;
      cpu_reset      <= 1'b1;
      done           <= 1'b0;
      error          <= 1'b0;
      words_loaded   <= '0;
    end else begin
      bus.mem_w <= 1'b0;
      case (state)
        ST_IDLE: begin
          bus.in_ready <= 1'b1;
          if (accept) begin
            if (hdr_n > RAM_LIMIT) begin
              state        <= ST_ERR;
              bus.in_ready <= 1'b0;
              error        <= 1'b1;
            end else begin
              state        <= ST_DATA;
              words_loaded <= '0;
            end
          end
        end
        ST_DATA: begin
          if (word_ready) begin
            state          <= ST_WRITE;
            bus.in_ready   <= 1'b0;
            bus.mem_w      <= 1'b1;
            bus.mem_addr   <= words_loaded[ADDR_W-1:0];
            bus.mem_w_data <= word_next;
          end
        end
        ST_WRITE: begin
          words_loaded <= wl_inc;
          if (wl_inc == n_words) begin
`ifdef LOADER_CHECKSUM_EN
            state        <= ST_CHK;
            bus.in_ready <= 1'b1;
`else
            state        <= ST_DONE;
            done         <= 1'b1;
            cpu_reset    <= 1'b0;
`endif
          end else begin
            state        <= ST_DATA;
            bus.in_ready <= 1'b1;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        ST_CHK: begin
          if (accept) begin
            bus.in_ready <= 1'b0;
            if ((csum ^ bus.in_byte) == 8'd0) begin
              state     <= ST_DONE;
              done      <= 1'b1;
              cpu_reset <= 1'b0;
            end else begin
              state <= ST_ERR;
              error <= 1'b1;
            end
          end
        end
`endif
        ST_DONE, ST_ERR: begin
          if (start) begin
            state        <= ST_IDLE;
            bus.in_ready <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            cpu_reset    <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Testbench for program_loader: directed sequence with random images,
// random valid gaps and a reference model of the expected RAM writes.
`timescale 1ns/1ps
module tb_program_loader;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, start16;
  logic       cpu_reset, done, error;
  logic [8:0] words_loaded;
  logic       cpu_reset16, done16, error16;
  logic [8:0] words_loaded16;

  program_loader_if #(.ADDR_W(8)) bus ();
  program_loader_if #(.ADDR_W(8)) bus16 ();

  program_loader #(.RAM_SIZE(256), .ADDR_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .start        (start),
    .cpu_reset    (cpu_reset),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  program_loader #(.RAM_SIZE(16), .ADDR_W(8)) dut16 (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus16),
    .start        (start16),
    .cpu_reset    (cpu_reset16),
    .done         (done16),
    .error        (error16),
    .words_loaded (words_loaded16)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0]  obs_addr_q[$];
  logic [31:0] obs_data_q[$];
  logic [31:0] obs_ram[256];
  logic [31:0] exp_ram[256];
  int          mw16_cnt = 0;
  logic        prev_mw  = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write monitor: records every RAM write and checks the write-cycle handshake.
  always @(negedge clk) begin
    if (bus.mem_w === 1'b1) begin
      chk("write_in_ready_low", {63'd0, bus.in_ready}, 64'd0);
      chk("write_single_cycle", {63'd0, prev_mw}, 64'd0);
      obs_addr_q.push_back(bus.mem_addr);
      obs_data_q.push_back(bus.mem_w_data);
      obs_ram[bus.mem_addr] = bus.mem_w_data;
    end
    prev_mw = bus.mem_w;
    if (bus16.mem_w === 1'b1) mw16_cnt++;
  end

  task automatic send(input logic [7:0] b, input bit gaps);
    int t;
    if (gaps) begin
      bus.in_valid = 1'b0;
      repeat ($urandom_range(0, 3)) tick();
    end
    bus.in_valid = 1'b1;
    bus.in_byte  = b;
    t = 0;
    while (bus.in_ready !== 1'b1 && t < 50) begin
      tick();
      t++;
    end
    chk("send_ready", {63'd0, bus.in_ready}, 64'd1);
    tick();
  endtask

  task automatic make_img(input int n, output bq_t img);
    img.delete();
    img.push_back((n == 256) ? 8'd0 : 8'(n));
    for (int i = 0; i < 4 * n; i++) img.push_back(8'($urandom_range(0, 255)));
  endtask

  // Sends a complete image and checks writes, completion timing and count
  // against words assembled directly from the image bytes.
  task automatic load(input bq_t img, input bit gaps);
    int          n;
    logic [31:0] w;
    logic [7:0]  x;
    n = (img[0] == 8'd0) ? 256 : int'(img[0]);
    obs_addr_q.delete();
    obs_data_q.delete();
    for (int k = 0; k < img.size(); k++) send(img[k], gaps);
    chk("last_mem_w", {63'd0, bus.mem_w}, 64'd1);
    chk("last_mem_addr", {56'd0, bus.mem_addr}, 64'(n - 1));
    chk("cpu_reset_during_write", {63'd0, cpu_reset}, 64'd1);
    bus.in_valid = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    x = 8'd0;
    foreach (img[k]) x ^= img[k];
    send(x, gaps);
    bus.in_valid = 1'b0;
`else
    x = 8'd0;
    tick();
`endif
    chk("done_after_load", {63'd0, done}, 64'd1);
    chk("cpu_reset_released", {63'd0, cpu_reset}, 64'd0);
    chk("no_error", {63'd0, error}, 64'd0);
    chk("words_loaded", {55'd0, words_loaded}, 64'(n));
    chk("write_count", 64'(obs_data_q.size()), 64'(n));
    for (int i = 0; i < n && i < obs_data_q.size(); i++) begin
      w = {img[1 + 4*i], img[2 + 4*i], img[3 + 4*i], img[4 + 4*i]};
      exp_ram[i] = w;
      chk($sformatf("addr_%0d", i), {56'd0, obs_addr_q[i]}, 64'(i));
      chk($sformatf("data_%0d", i), {32'd0, obs_data_q[i]}, {32'd0, w});
    end
  endtask

  task automatic restart();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_done", {63'd0, done}, 64'd0);
    chk("restart_error", {63'd0, error}, 64'd0);
    chk("restart_cpu_reset", {63'd0, cpu_reset}, 64'd1);
    chk("restart_in_ready", {63'd0, bus.in_ready}, 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bq_t img;
    int  n;

    reset = 1'b1; start = 1'b0; start16 = 1'b0;
    bus.in_valid = 1'b0;   bus.in_byte = 8'd0;
    bus16.in_valid = 1'b0; bus16.in_byte = 8'd0;
    foreach (obs_ram[i]) obs_ram[i] = 32'd0;
    tick(); tick();

    // Reset values
    chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
    chk("rst_mem_w", {63'd0, bus.mem_w}, 64'd0);
    chk("rst_mem_addr", {56'd0, bus.mem_addr}, 64'd0);
    chk("rst_mem_w_data", {32'd0, bus.mem_w_data}, 64'd0);
    chk("rst_cpu_reset", {63'd0, cpu_reset}, 64'd1);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_error", {63'd0, error}, 64'd0);
    chk("rst_words_loaded", {55'd0, words_loaded}, 64'd0);
    reset = 1'b0;
    tick(); tick();
    chk("idle_in_ready", {63'd0, bus.in_ready}, 64'd1);

    // Normal two-word load, back-to-back bytes
    img = '{8'h02, 8'h00, 8'h04, 8'h00, 8'h2A, 8'h00, 8'h01, 8'h00, 8'h00};
    load(img, 1'b0);
    chk("normal_w0", {32'd0, obs_data_q[0]}, 64'h0004002A);
    chk("normal_w1", {32'd0, obs_data_q[1]}, 64'h00010000);

    // Bytes offered in DONE are refused
    bus.in_valid = 1'b1; bus.in_byte = 8'h55;
    repeat (3) tick();
    chk("done_in_ready", {63'd0, bus.in_ready}, 64'd0);
    chk("done_no_write", 64'(obs_data_q.size()), 64'd2);
    chk("done_hold", {63'd0, done}, 64'd1);
    bus.in_valid = 1'b0;
    restart();

    // Random images, with and without valid gaps
    for (int rep = 0; rep < 3; rep++) begin
      n = $urandom_range(1, 8);
      make_img(n, img);
      load(img, rep[0]);
      restart();
    end

    // Same image with and without gaps must leave identical RAM contents
    n = $urandom_range(3, 10);
    make_img(n, img);
    load(img, 1'b0);
    restart();
    for (int i = 0; i < n; i++) obs_ram[i] = 32'd0;
    load(img, 1'b1);
    for (int i = 0; i < n; i++)
      chk($sformatf("gap_ram_%0d", i), {32'd0, obs_ram[i]}, {32'd0, exp_ram[i]});
    restart();

    // Header 0x00 fills all 256 words
    make_img(256, img);
    load(img, 1'b0);
    chk("full_last_addr", {56'd0, obs_addr_q[obs_addr_q.size() - 1]}, 64'hFF);
    restart();

    // Oversize header on the 16-word instance
    bus16.in_valid = 1'b1; bus16.in_byte = 8'h20;
    chk("ovs_ready_before", {63'd0, bus16.in_ready}, 64'd1);
    tick();
    chk("ovs_error", {63'd0, error16}, 64'd1);
    chk("ovs_cpu_reset", {63'd0, cpu_reset16}, 64'd1);
    chk("ovs_done", {63'd0, done16}, 64'd0);
    repeat (3) tick();
    chk("ovs_in_ready", {63'd0, bus16.in_ready}, 64'd0);
    chk("ovs_no_write", 64'(mw16_cnt), 64'd0);
    bus16.in_valid = 1'b0;
    start16 = 1'b1;
    tick();
    start16 = 1'b0;
    chk("ovs_start_error", {63'd0, error16}, 64'd0);
    chk("ovs_start_cpu_reset", {63'd0, cpu_reset16}, 64'd1);
    chk("ovs_start_ready", {63'd0, bus16.in_ready}, 64'd1);
    // One past the limit fails, exactly the limit is accepted
    bus16.in_valid = 1'b1; bus16.in_byte = 8'h11;
    tick();
    bus16.in_valid = 1'b0;
    chk("ovs17_error", {63'd0, error16}, 64'd1);
    start16 = 1'b1;
    tick();
    start16 = 1'b0;
    bus16.in_valid = 1'b1; bus16.in_byte = 8'h10;
    tick();
    bus16.in_valid = 1'b0;
    tick();
    chk("ovs16_accepted_error", {63'd0, error16}, 64'd0);
    chk("ovs16_accepted_ready", {63'd0, bus16.in_ready}, 64'd1);

    // Reset in the middle of a word, then a fresh load
    obs_addr_q.delete();
    obs_data_q.delete();
    send(8'h01, 1'b0);
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick(); tick();
    chk("midrst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("midrst_no_write", 64'(obs_data_q.size()), 64'd0);
    chk("midrst_done", {63'd0, done}, 64'd0);
    chk("midrst_cpu_reset", {63'd0, cpu_reset}, 64'd1);
    img = '{8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    load(img, 1'b0);
    chk("midrst_word", {32'd0, obs_data_q[0]}, 64'hDEADBEEF);
    chk("midrst_addr", {56'd0, obs_addr_q[0]}, 64'd0);

`ifdef LOADER_CHECKSUM_EN
    // Trailer checks on a fixed image
    restart();
    img = '{8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    foreach (img[k]) send(img[k], 1'b0);
    bus.in_valid = 1'b0;
    send(8'h45, 1'b0);
    bus.in_valid = 1'b0;
    chk("csum_good_done", {63'd0, done}, 64'd1);
    chk("csum_good_cpu_reset", {63'd0, cpu_reset}, 64'd0);
    restart();
    foreach (img[k]) send(img[k], 1'b0);
    bus.in_valid = 1'b0;
    send(8'h00, 1'b0);
    bus.in_valid = 1'b0;
    chk("csum_bad_error", {63'd0, error}, 64'd1);
    chk("csum_bad_done", {63'd0, done}, 64'd0);
    chk("csum_bad_cpu_reset", {63'd0, cpu_reset}, 64'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Byte-stream loader that fills the CPU's 32-bit program RAM; it is the writer side of the RAM that the CPU core fetches from.
- Receives a framed byte stream over a valid/ready handshake: one header byte, then 4 bytes per instruction word.
- Packs each group of 4 bytes into a 32-bit instruction word and writes it to sequential RAM addresses.
- Holds the CPU in reset until the image is fully and correctly loaded.

Parameters:
- RAM_SIZE, 256, number of 32-bit words in program RAM (1..256).
- ADDR_W, 8, RAM word-address width; matches the 8-bit PC.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  in_byte carries a valid byte this cycle.
- in_byte  input  8  stream byte.
- in_ready  output  1  loader can accept a byte; a byte transfers when in_valid && in_ready.
- start  input  1  single-cycle pulse; re-arms the loader from DONE or ERR.
- mem_w  output  1  RAM write strobe, one cycle per word.
- mem_addr  output  ADDR_W  word address for the write.
- mem_w_data  output  32  instruction word; first stream byte is [31:24].
- cpu_reset  output  1  drives the CPU core reset; high while not DONE.
- done  output  1  image loaded; level signal.
- error  output  1  load aborted; level signal.
- words_loaded  output  ADDR_W+1  count of words written in the current load.

Behaviour:
- Reset values: in_ready=0, mem_w=0, mem_addr=0, mem_w_data=0, cpu_reset=1, done=0, error=0, words_loaded=0. State after reset is IDLE.
- IDLE: in_ready=1.
  - An accepted byte is the header N: word count.
  - N=0 means 256.
  - N>RAM_SIZE goes to ERR.
  - Otherwise latch N, clear the byte index and words_loaded, and go to DATA.
- DATA: in_ready=1.
  - Each accepted byte shifts into a 32-bit packer, big-endian.
  - The byte index wraps 0..3.
  - On the 4th byte, go to WRITE.
- WRITE: exactly one cycle.
  - in_ready=0, mem_w=1, mem_addr=words_loaded[ADDR_W-1:0], mem_w_data=packed word.
  - mem_w is asserted in the cycle immediately after the 4th byte is accepted (latency 1).
  - words_loaded increments at the end of the cycle.
  - If the new count equals N, go to DONE (or CHK, see Optional Feature); else go to DATA.
- DONE: in_ready=0, done=1, cpu_reset=0 (registered, so it falls one cycle after the last mem_w).
- ERR: in_ready=0, error=1, cpu_reset=1. Bytes presented in DONE or ERR are not accepted.
- start:
  - In DONE or ERR, start moves the loader to IDLE in the next cycle: done/error clear, cpu_reset goes high.
  - In IDLE, DATA, or WRITE, start is ignored.
- Gaps in in_valid simply stall the loader; there is no timeout.
- Simultaneous reset and any other input: reset wins.
- Reset mid-load: return to IDLE and discard the partial word. Words already written stay in RAM; the loader never clears RAM.
- Address wrap: mem_addr never exceeds N-1 ≤ RAM_SIZE-1, so no wrap occurs.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- With the macro:
  - The stream ends with a trailer byte after the last word.
  - A running XOR is kept over the header and all data bytes.
  - After the last WRITE, enter CHK with in_ready=1.
  - On the accepted trailer byte: if running XOR ^ trailer == 0, go to DONE; else go to ERR.
  - cpu_reset stays high until the check passes.
- Without the macro: no CHK state and no trailer byte; the last WRITE goes directly to DONE.

Decomposition:
- Package loader_pkg holds:
  - the state encoding (IDLE, DATA, WRITE, CHK, DONE, ERR);
  - BYTES_PER_WORD=4;
  - HDR_ZERO_MEANS_256 constant;
  - the big-endian byte-lane mapping.
- One sub-module, byte_packer: 32-bit shift register plus 2-bit byte index, with a word_ready output. The FSM and counters live in program_loader.

Test Plan:
- Normal load, back-to-back valid: header 0x02, then bytes 00 04 00 2A and 00 01 00 00.
  - Required: mem_w at addr 0 with 0x0004002A, then at addr 1 with 0x00010000.
  - Then done=1 and cpu_reset=0 one cycle after the second write; words_loaded=2.
- Backpressure: hold in_valid=1 throughout.
  - Required: in_ready=0 exactly in each WRITE cycle; no byte lost or duplicated.
  - Random in_valid gaps produce identical RAM contents.
- Full RAM with header 0x00 (RAM_SIZE=256): required 256 writes, last at addr 0xFF; words_loaded=256; done=1.
- Oversize header with RAM_SIZE=16, header 0x20: required error=1 next cycle, no mem_w, cpu_reset=1. A start pulse then returns the loader to IDLE with error=0.
- Reset after header 0x01 plus 2 data bytes: required IDLE, in_ready=1, no mem_w. A fresh load of 0x01 + DE AD BE EF then writes 0xDEADBEEF at addr 0.
- With LOADER_CHECKSUM_EN, image 0x01 + 11 22 33 44:
  - Trailer 0x45: done=1.
  - Trailer 0x00: error=1, done=0, cpu_reset=1.
